// File: rtl/main_counter_ext.sv
// UTIM main counter: prescaled up/down/periodic/one-shot timer with lane-masked
// counter and reload writes, a capture register and a registered single-cycle event.
module main_counter_ext #(
  parameter int P_WIDTH     = 64,
  parameter int P_PSC_WIDTH = 8
)(
  input  logic                     iCLOCK,
  input  logic                     iRESET,
  input  logic                     iCONF_WRITE,
  input  logic                     iCONF_ENA,
  input  logic [1:0]               iCONF_MODE,
  input  logic [P_PSC_WIDTH-1:0]   iCONF_PSC,
  input  logic                     iCOUNT_WRITE,
  input  logic [P_WIDTH/32-1:0]    inCOUNT_DQM,
  input  logic [P_WIDTH-1:0]       iCOUNT_COUNTER,
  input  logic                     iRELOAD_WRITE,
  input  logic [P_WIDTH/32-1:0]    inRELOAD_DQM,
  input  logic [P_WIDTH-1:0]       iRELOAD_DATA,
  input  logic                     iCAPTURE,
  output logic                     oWORKING,
  output logic [1:0]               oMODE,
  output logic [P_WIDTH-1:0]       oCOUNTER,
  output logic [P_WIDTH-1:0]       oRELOAD,
  output logic [P_WIDTH-1:0]       oCAPTURE,
  output logic                     oEVENT
);

  localparam int L = P_WIDTH / 32;

  localparam logic [1:0] MODE_UP       = 2'b00;
  localparam logic [1:0] MODE_DOWN     = 2'b01;
  localparam logic [1:0] MODE_PERIODIC = 2'b10;
  localparam logic [1:0] MODE_ONESHOT  = 2'b11;

  localparam logic [P_WIDTH-1:0]     CNT_ZERO = {P_WIDTH{1'b0}};
  localparam logic [P_WIDTH-1:0]     CNT_ONES = {P_WIDTH{1'b1}};
  localparam logic [P_WIDTH-1:0]     CNT_ONE  = {{(P_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [P_PSC_WIDTH-1:0] PSC_ZERO = {P_PSC_WIDTH{1'b0}};
  localparam logic [P_PSC_WIDTH-1:0] PSC_ONE  = {{(P_PSC_WIDTH-1){1'b0}}, 1'b1};

  logic                   workingR;
  logic [1:0]             modeR;
  logic [P_PSC_WIDTH-1:0] pscCfgR;
  logic [P_PSC_WIDTH-1:0] pscCntR;
  logic [P_WIDTH-1:0]     counterR;
  logic [P_WIDTH-1:0]     reloadR;
  logic [P_WIDTH-1:0]     captureR;
  logic                   eventR;

  logic                   tickS;
  logic                   isZeroS;
  logic [P_WIDTH-1:0]     countMergeS;
  logic [P_WIDTH-1:0]     reloadMergeS;
  logic [P_WIDTH-1:0]     counterNextS;
  logic                   eventNextS;
  logic                   workingNextS;
  logic [P_PSC_WIDTH-1:0] pscCntNextS;

  // A config write restarts the prescaler, so it never coincides with a tick.
  assign tickS   = workingR & ~iCONF_WRITE & (pscCntR == pscCfgR);
  assign isZeroS = (counterR == CNT_ZERO);

  // Lane-masked merge of write data over the current counter and reload values.
  always_comb begin
    countMergeS  = counterR;
    reloadMergeS = reloadR;
    for (int i = 0; i < L; i++) begin
      if (!inCOUNT_DQM[i]) begin
        countMergeS[32*i +: 32] = iCOUNT_COUNTER[32*i +: 32];
      end else begin
        countMergeS[32*i +: 32] = counterR[32*i +: 32];
      end
      if (!inRELOAD_DQM[i]) begin
        reloadMergeS[32*i +: 32] = iRELOAD_DATA[32*i +: 32];
      end else begin
        reloadMergeS[32*i +: 32] = reloadR[32*i +: 32];
      end
    end
  end

  // Prescaler next count.
  always_comb begin
    pscCntNextS = pscCntR;
    if (iCONF_WRITE) begin
      pscCntNextS = PSC_ZERO;
    end else if (workingR) begin
      if (pscCntR == pscCfgR) begin
        pscCntNextS = PSC_ZERO;
      end else begin
        pscCntNextS = pscCntR + PSC_ONE;
      end
    end else begin
      pscCntNextS = pscCntR;
    end
  end

  // Counter, event and run-state next values; counter writes only land while stopped.
  always_comb begin
    counterNextS = counterR;
    eventNextS   = 1'b0;
    workingNextS = workingR;
    if (iCONF_WRITE) begin
      workingNextS = iCONF_ENA;
    end else begin
      workingNextS = workingR;
    end
    if (iCOUNT_WRITE && !workingR) begin
      counterNextS = countMergeS;
    end else if (tickS) begin
      case (modeR)
        MODE_UP: begin
          counterNextS = counterR + CNT_ONE;
          eventNextS   = (counterR == CNT_ONES);
        end
        MODE_DOWN: begin
          counterNextS = counterR - CNT_ONE;
          eventNextS   = isZeroS;
        end
        MODE_PERIODIC: begin
          if (isZeroS) begin
            counterNextS = reloadR;
            eventNextS   = 1'b1;
          end else begin
            counterNextS = counterR - CNT_ONE;
          end
        end
        MODE_ONESHOT: begin
          if (isZeroS) begin
            counterNextS = CNT_ZERO;
            eventNextS   = 1'b1;
            workingNextS = 1'b0;
          end else begin
            counterNextS = counterR - CNT_ONE;
          end
        end
        default: begin
          counterNextS = counterR;
          eventNextS   = 1'b0;
        end
      endcase
    end else begin
      counterNextS = counterR;
    end
  end

  // State registers.
  always_ff @(posedge iCLOCK or posedge iRESET) begin
    if (iRESET) begin
      workingR <= 1'b0;
      modeR    <= MODE_UP;
      pscCfgR  <= PSC_ZERO;
      pscCntR  <= PSC_ZERO;
      counterR <= CNT_ZERO;
      reloadR  <= CNT_ZERO;
      captureR <= CNT_ZERO;
      eventR   <= 1'b0;
    end else begin
      workingR <= workingNextS;
      pscCntR  <= pscCntNextS;
      counterR <= counterNextS;
      eventR   <= eventNextS;
      if (iCONF_WRITE) begin
        modeR   <= iCONF_MODE;
        pscCfgR <= iCONF_PSC;
      end
      if (iRELOAD_WRITE) begin
        reloadR <= reloadMergeS;
      end
      if (iCAPTURE) begin
        captureR <= counterR;
      end
    end
  end

  assign oWORKING = workingR;
  assign oMODE    = modeR;
  assign oCOUNTER = counterR;
  assign oRELOAD  = reloadR;
  assign oCAPTURE = captureR;
  assign oEVENT   = eventR;

endmodule

// File: tb/tb_main_counter_ext.sv
// Scoreboard bench for main_counter_ext: a behavioural model predicts the state after
// each edge, a monitor compares it against the DUT one time unit after that edge.
module tb_main_counter_ext;

  localparam int W  = 64;
  localparam int PW = 8;
  localparam int L  = W / 32;

  logic          iCLOCK;
  logic          iRESET;
  logic          iCONF_WRITE;
  logic          iCONF_ENA;
  logic [1:0]    iCONF_MODE;
  logic [PW-1:0] iCONF_PSC;
  logic          iCOUNT_WRITE;
  logic [L-1:0]  inCOUNT_DQM;
  logic [W-1:0]  iCOUNT_COUNTER;
  logic          iRELOAD_WRITE;
  logic [L-1:0]  inRELOAD_DQM;
  logic [W-1:0]  iRELOAD_DATA;
  logic          iCAPTURE;
  logic          oWORKING;
  logic [1:0]    oMODE;
  logic [W-1:0]  oCOUNTER;
  logic [W-1:0]  oRELOAD;
  logic [W-1:0]  oCAPTURE;
  logic          oEVENT;

  main_counter_ext #(.P_WIDTH(W), .P_PSC_WIDTH(PW)) dut (
    .iCLOCK(iCLOCK), .iRESET(iRESET),
    .iCONF_WRITE(iCONF_WRITE), .iCONF_ENA(iCONF_ENA), .iCONF_MODE(iCONF_MODE), .iCONF_PSC(iCONF_PSC),
    .iCOUNT_WRITE(iCOUNT_WRITE), .inCOUNT_DQM(inCOUNT_DQM), .iCOUNT_COUNTER(iCOUNT_COUNTER),
    .iRELOAD_WRITE(iRELOAD_WRITE), .inRELOAD_DQM(inRELOAD_DQM), .iRELOAD_DATA(iRELOAD_DATA),
    .iCAPTURE(iCAPTURE),
    .oWORKING(oWORKING), .oMODE(oMODE), .oCOUNTER(oCOUNTER), .oRELOAD(oRELOAD),
    .oCAPTURE(oCAPTURE), .oEVENT(oEVENT)
  );

  typedef struct {
    logic         w;
    logic [1:0]   m;
    logic [W-1:0] c;
    logic [W-1:0] r;
    logic [W-1:0] cap;
    logic         e;
    int           cyc;
  } exp_t;

  exp_t expQ[$];
  int nVec = 0;
  int nMis = 0;
  int cycNo = 0;

  // Reference model state.
  logic          mWorking;
  logic [1:0]    mMode;
  int unsigned   mPsc;
  longint unsigned mAge;
  logic [W-1:0]  mCounter;
  logic [W-1:0]  mReload;
  logic [W-1:0]  mCapture;

  initial begin
    iCLOCK = 1'b0;
    forever #5 iCLOCK = ~iCLOCK;
  end

  function automatic logic [W-1:0] laneMerge(input logic [W-1:0] old, input logic [W-1:0] d,
                                             input logic [L-1:0] nMask);
    logic [W-1:0] r;
    r = old;
    for (int i = 0; i < L; i++) if (!nMask[i]) r[32*i +: 32] = d[32*i +: 32];
    return r;
  endfunction

  task automatic modelReset();
    mWorking = 1'b0; mMode = 2'b00; mPsc = 0; mAge = 0;
    mCounter = '0; mReload = '0; mCapture = '0;
  endtask

  // Predict the state after the coming edge from the driven inputs, then enqueue it.
  task automatic modelStep();
    logic tick;
    logic [W-1:0] nc;
    logic ne;
    logic nw;
    exp_t x;
    tick = mWorking && !iCONF_WRITE && (((mAge + 1) % longint'(mPsc + 1)) == 0);
    nc = mCounter; ne = 1'b0; nw = mWorking;
    if (iCOUNT_WRITE && !mWorking) nc = laneMerge(mCounter, iCOUNT_COUNTER, inCOUNT_DQM);
    else if (tick) begin
      case (mMode)
        2'b00: begin nc = mCounter + 64'd1; ne = (nc == 64'd0); end
        2'b01: begin nc = mCounter - 64'd1; ne = (mCounter == 64'd0); end
        2'b10: if (mCounter == 64'd0) begin nc = mReload; ne = 1'b1; end else nc = mCounter - 64'd1;
        default: if (mCounter == 64'd0) begin ne = 1'b1; nw = 1'b0; end else nc = mCounter - 64'd1;
      endcase
    end
    if (iCAPTURE) mCapture = mCounter;
    if (iRELOAD_WRITE) mReload = laneMerge(mReload, iRELOAD_DATA, inRELOAD_DQM);
    if (iCONF_WRITE) begin
      nw = iCONF_ENA; mMode = iCONF_MODE; mPsc = int'(iCONF_PSC); mAge = 0;
    end else if (mWorking) begin
      mAge = mAge + 1;
    end
    mWorking = nw;
    mCounter = nc;
    x.w = mWorking; x.m = mMode; x.c = mCounter; x.r = mReload; x.cap = mCapture; x.e = ne;
    x.cyc = cycNo;
    expQ.push_back(x);
  endtask

  task automatic idleInputs();
    iCONF_WRITE = 1'b0; iCONF_ENA = 1'b0; iCONF_MODE = 2'b00; iCONF_PSC = '0;
    iCOUNT_WRITE = 1'b0; inCOUNT_DQM = '1; iCOUNT_COUNTER = '0;
    iRELOAD_WRITE = 1'b0; inRELOAD_DQM = '1; iRELOAD_DATA = '0; iCAPTURE = 1'b0;
  endtask

  // One clock: inputs already driven at the falling edge.
  task automatic cyc();
    modelStep();
    @(posedge iCLOCK);
    @(negedge iCLOCK);
    cycNo++;
    idleInputs();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic conf(input logic ena, input logic [1:0] mode, input logic [PW-1:0] psc);
    iCONF_WRITE = 1'b1; iCONF_ENA = ena; iCONF_MODE = mode; iCONF_PSC = psc;
    cyc();
  endtask

  task automatic wrCount(input logic [W-1:0] d, input logic [L-1:0] nm);
    iCOUNT_WRITE = 1'b1; iCOUNT_COUNTER = d; inCOUNT_DQM = nm;
    cyc();
  endtask

  task automatic wrReload(input logic [W-1:0] d, input logic [L-1:0] nm);
    iRELOAD_WRITE = 1'b1; iRELOAD_DATA = d; inRELOAD_DQM = nm;
    cyc();
  endtask

  task automatic chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] want);
    nVec++;
    if (got !== want) begin
      nMis++;
      $display("FAIL %s: got %h, expected %h", nm, got, want);
    end
  endtask

  task automatic chkAllZero(input string nm);
    chk({nm, "_working"}, {63'd0, oWORKING}, 64'd0);
    chk({nm, "_mode"}, {62'd0, oMODE}, 64'd0);
    chk({nm, "_counter"}, oCOUNTER, 64'd0);
    chk({nm, "_reload"}, oRELOAD, 64'd0);
    chk({nm, "_capture"}, oCAPTURE, 64'd0);
    chk({nm, "_event"}, {63'd0, oEVENT}, 64'd0);
  endtask

  function automatic logic [W-1:0] randData();
    logic [W-1:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0: r = 64'd0;
      1: r = {W{1'b1}};
      2: r = 64'($urandom_range(0, 6));
      3: r = {W{1'b1}} - 64'($urandom_range(0, 6));
      default: ;
    endcase
    return r;
  endfunction

  // Monitor: one expected record per edge, compared just after that edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge iCLOCK);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        nVec++;
        if (oWORKING !== e.w || oMODE !== e.m || oCOUNTER !== e.c || oRELOAD !== e.r ||
            oCAPTURE !== e.cap || oEVENT !== e.e) begin
          nMis++;
          $display("FAIL scoreboard cyc %0d: got w=%b m=%b cnt=%h rld=%h cap=%h ev=%b, expected w=%b m=%b cnt=%h rld=%h cap=%h ev=%b",
                   e.cyc, oWORKING, oMODE, oCOUNTER, oRELOAD, oCAPTURE, oEVENT,
                   e.w, e.m, e.c, e.r, e.cap, e.e);
        end
      end
    end
  end

  initial begin
    idleInputs();
    modelReset();
    iRESET = 1'b0;
    #1 iRESET = 1'b1;
    #2 chkAllZero("reset");
    @(negedge iCLOCK);
    iRESET = 1'b0;

    // Up-count wrap from all-ones.
    wrCount(64'hFFFF_FFFF_FFFF_FFFE, 2'b00);
    conf(1'b1, 2'b00, 8'd0);
    run(6);

    // Lane-masked write while stopped, ignored write while running.
    conf(1'b0, 2'b00, 8'd0);
    wrCount(64'd0, 2'b00);
    wrCount(64'h1111_2222_3333_4444, 2'b10);
    chk("dqm_lane_write", oCOUNTER, 64'h0000_0000_3333_4444);
    conf(1'b1, 2'b00, 8'd0);
    wrCount(64'h1111_2222_3333_4444, 2'b10);
    run(3);

    // Periodic with reload 3, psc 1.
    conf(1'b0, 2'b00, 8'd0);
    wrReload(64'd3, 2'b00);
    wrCount(64'd0, 2'b00);
    conf(1'b1, 2'b10, 8'd1);
    run(20);

    // One-shot from 2.
    conf(1'b0, 2'b00, 8'd0);
    wrCount(64'd2, 2'b00);
    conf(1'b1, 2'b11, 8'd0);
    run(8);

    // Down from 0 with psc 2, capture on the wrapping edge.
    conf(1'b0, 2'b00, 8'd0);
    wrCount(64'd0, 2'b00);
    conf(1'b1, 2'b01, 8'd2);
    run(2);
    iCAPTURE = 1'b1;
    cyc();
    chk("capture_before_wrap", oCAPTURE, 64'd0);
    run(3);

    // Async reset between edges while running periodic.
    conf(1'b0, 2'b00, 8'd0);
    wrReload(64'd5, 2'b00);
    wrCount(64'd0, 2'b00);
    conf(1'b1, 2'b10, 8'd0);
    run(4);
    #2 iRESET = 1'b1;
    #1 chkAllZero("async_reset");
    @(negedge iCLOCK);
    iRESET = 1'b0;
    modelReset();
    run(4);

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) begin
        iCONF_WRITE = 1'b1;
        iCONF_ENA = ($urandom_range(0, 3) != 0);
        iCONF_MODE = 2'($urandom_range(0, 3));
        iCONF_PSC = 8'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 5) == 0) begin
        iCOUNT_WRITE = 1'b1; iCOUNT_COUNTER = randData(); inCOUNT_DQM = 2'($urandom_range(0, 3));
      end
      if ($urandom_range(0, 7) == 0) begin
        iRELOAD_WRITE = 1'b1; iRELOAD_DATA = randData(); inRELOAD_DQM = 2'($urandom_range(0, 3));
      end
      iCAPTURE = ($urandom_range(0, 9) == 0);
      cyc();
    end

    for (int i = 0; i < 5 && expQ.size() > 0; i++) @(negedge iCLOCK);
    if (expQ.size() > 0) begin
      nMis++;
      $display("FAIL drain: %0d expected records left, expected 0", expQ.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", nVec, nMis);
    $finish;
  end

endmodule
